// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: iterative radix-2 DIT FFT controller that loads a frame bit-reversed,
// runs it through one shared butterfly stage NPOINT times, then presents the result downstream.
module fft_stage_sequencer #(
    parameter int WIDTH = 16,
    parameter int NPOINT = 3,
    localparam int N = 1 << NPOINT,
    localparam int STEP_W = (NPOINT > 1) ? $clog2(NPOINT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid_i,
    output logic                 din_busy_o,
    input  logic [WIDTH*N-1:0]   din_real_i,
    input  logic [WIDTH*N-1:0]   din_imag_i,
    output logic                 bf_din_valid_o,
    output logic [STEP_W-1:0]    bf_step_o,
    output logic [WIDTH*N-1:0]   bf_din_real_o,
    output logic [WIDTH*N-1:0]   bf_din_imag_o,
    input  logic                 bf_dout_valid_i,
    input  logic [WIDTH*N-1:0]   bf_dout_real_i,
    input  logic [WIDTH*N-1:0]   bf_dout_imag_i,
    output logic                 dout_valid_o,
    input  logic                 dout_busy_i,
    output logic [WIDTH*N-1:0]   dout_real_o,
    output logic [WIDTH*N-1:0]   dout_imag_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(NPOINT - 1);
    state_t state_q, state_d;
    logic [STEP_W-1:0] s_q, s_d;
    logic [WIDTH*N-1:0] re_q, re_d, im_q, im_d, rev_re, rev_im;

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < NPOINT; b++) r = r | (((v >> b) & 1) << (NPOINT - 1 - b));
        return r;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_rev
        localparam int R = bitrev(i);
        assign rev_re[R*WIDTH +: WIDTH] = din_real_i[i*WIDTH +: WIDTH];
        assign rev_im[R*WIDTH +: WIDTH] = din_imag_i[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    // butterfly results are only accepted while waiting; strays elsewhere are dropped
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            IDLE: if (din_valid_i) begin
                state_d = ISSUE;
                s_d     = '0;
                re_d    = rev_re;
                im_d    = rev_im;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bf_dout_valid_i) begin
                re_d    = bf_dout_real_i;
                im_d    = bf_dout_imag_i;
                state_d = (s_q == LAST) ? OUT : ISSUE;
                s_d     = (s_q == LAST) ? s_q : s_q + STEP_W'(1);
            end
            OUT: if (!dout_busy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign din_busy_o     = state_q != IDLE;
    assign bf_din_valid_o = state_q == ISSUE;
    assign dout_valid_o   = state_q == OUT;
    assign bf_step_o      = s_q;
    assign bf_din_real_o  = re_q;
    assign bf_din_imag_o  = im_q;
    assign dout_real_o    = re_q;
    assign dout_imag_o    = im_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of the FFT stage sequencer with a latency-programmable
// add-one butterfly model and injectable stray butterfly results.
module tb_fft_stage_sequencer;
    localparam int W = 16, NP = 3, N = 8, FW = W * N;
    localparam logic [FW-1:0] RAMP     = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    localparam logic [FW-1:0] REV_RAMP = {16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0};
    localparam logic [FW-1:0] STAGE1   = {16'd8, 16'd4, 16'd6, 16'd2, 16'd7, 16'd3, 16'd5, 16'd1};
    localparam logic [FW-1:0] STAGE2   = {16'd9, 16'd5, 16'd7, 16'd3, 16'd8, 16'd4, 16'd6, 16'd2};
    localparam logic [FW-1:0] OUT_RAMP = {16'd10, 16'd6, 16'd8, 16'd4, 16'd9, 16'd5, 16'd7, 16'd3};
    localparam logic [FW-1:0] THREE    = {8{16'd3}};
    localparam logic [FW-1:0] JUNK     = {8{16'hBEEF}};
    localparam logic [FW-1:0] B_RE     = {16'd107, 16'd106, 16'd105, 16'd104, 16'd103, 16'd102, 16'd101, 16'd100};
    localparam logic [FW-1:0] B_REV_RE = {16'd107, 16'd103, 16'd105, 16'd101, 16'd106, 16'd102, 16'd104, 16'd100};
    localparam logic [FW-1:0] B_OUT_RE = {16'd110, 16'd106, 16'd108, 16'd104, 16'd109, 16'd105, 16'd107, 16'd103};

    logic clk = 0, rst = 0, din_valid = 0, dout_busy = 0, spur_v = 0, model_v = 0;
    logic din_busy, bf_din_valid, bf_dout_valid, dout_valid;
    logic [1:0] bf_step;
    logic [FW-1:0] din_real = '0, din_imag = '0, model_re = '0, model_im = '0;
    logic [FW-1:0] bf_din_real, bf_din_imag, bf_dout_real, bf_dout_imag, dout_real, dout_imag;
    int lat = 1, cnt = 0, n_tests = 0, n_fail = 0;

    fft_stage_sequencer #(.WIDTH(W), .NPOINT(NP)) dut (
        .clk(clk), .rst(rst),
        .din_valid_i(din_valid), .din_busy_o(din_busy),
        .din_real_i(din_real), .din_imag_i(din_imag),
        .bf_din_valid_o(bf_din_valid), .bf_step_o(bf_step),
        .bf_din_real_o(bf_din_real), .bf_din_imag_o(bf_din_imag),
        .bf_dout_valid_i(bf_dout_valid), .bf_dout_real_i(bf_dout_real), .bf_dout_imag_i(bf_dout_imag),
        .dout_valid_o(dout_valid), .dout_busy_i(dout_busy),
        .dout_real_o(dout_real), .dout_imag_o(dout_imag)
    );

    always #5 clk = ~clk;

    assign bf_dout_valid = model_v | spur_v;
    assign bf_dout_real  = spur_v ? JUNK : model_re;
    assign bf_dout_imag  = spur_v ? JUNK : model_im;

    // butterfly: answers each start pulse lat cycles later with every lane incremented
    always @(negedge clk) begin
        model_v <= (cnt == 1);
        if (cnt > 0) cnt <= cnt - 1;
        if (bf_din_valid) begin
            cnt <= lat;
            for (int j = 0; j < N; j++) begin
                model_re[j*W +: W] <= bf_din_real[j*W +: W] + 16'd1;
                model_im[j*W +: W] <= bf_din_imag[j*W +: W] + 16'd1;
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1; din_valid = 1'($urandom); dout_busy = 1'($urandom); spur_v = 1'($urandom);
        din_real = {$urandom, $urandom, $urandom, $urandom}; din_imag = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        din_valid = 1'($urandom); dout_busy = 1'($urandom); spur_v = 1'($urandom);
        @(negedge clk);
        rst = 0; din_valid = 0; dout_busy = 0; spur_v = 0;
        @(negedge clk);
        n_tests++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL reset din_busy got %0d want 0", din_busy); end
        n_tests++; if (bf_din_valid !== 1'b0) begin n_fail++; $display("FAIL reset bf_din_valid got %0d want 0", bf_din_valid); end
        n_tests++; if (bf_step !== 2'd0) begin n_fail++; $display("FAIL reset bf_step got %0d want 0", bf_step); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset dout_valid got %0d want 0", dout_valid); end
        n_tests++; if (bf_din_real !== '0) begin n_fail++; $display("FAIL reset bf_din_real got %h want 0", bf_din_real); end
        n_tests++; if (bf_din_imag !== '0) begin n_fail++; $display("FAIL reset bf_din_imag got %h want 0", bf_din_imag); end
        n_tests++; if (dout_real !== '0) begin n_fail++; $display("FAIL reset dout_real got %h want 0", dout_real); end
        n_tests++; if (dout_imag !== '0) begin n_fail++; $display("FAIL reset dout_imag got %h want 0", dout_imag); end
    endtask

    task automatic test_single_frame(input string tag);
        lat = 1;
        @(negedge clk);
        din_real = RAMP; din_imag = '0; din_valid = 1;
        n_tests++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL %s idle din_busy got %0d want 0", tag, din_busy); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            din_valid = 0;
            n_tests++; if (bf_din_valid !== 1'(k == 1 || k == 3 || k == 5)) begin n_fail++; $display("FAIL %s bf_din_valid c%0d got %0d", tag, k, bf_din_valid); end
            if (k == 1 || k == 3 || k == 5) begin
                n_tests++; if (bf_step !== 2'((k - 1) / 2)) begin n_fail++; $display("FAIL %s bf_step c%0d got %0d want %0d", tag, k, bf_step, (k - 1) / 2); end
            end
            n_tests++; if (dout_valid !== 1'(k == 7)) begin n_fail++; $display("FAIL %s dout_valid c%0d got %0d", tag, k, dout_valid); end
            n_tests++; if (din_busy !== 1'(k < 8)) begin n_fail++; $display("FAIL %s din_busy c%0d got %0d", tag, k, din_busy); end
            if (k == 1) begin
                n_tests++; if (bf_din_real !== REV_RAMP) begin n_fail++; $display("FAIL %s bitrev load got %h want %h", tag, bf_din_real, REV_RAMP); end
            end
            if (k == 3) begin
                n_tests++; if (bf_din_real !== STAGE1) begin n_fail++; $display("FAIL %s stage1 buf got %h want %h", tag, bf_din_real, STAGE1); end
            end
            if (k == 7) begin
                n_tests++; if (dout_real !== OUT_RAMP) begin n_fail++; $display("FAIL %s dout_real got %h want %h", tag, dout_real, OUT_RAMP); end
                n_tests++; if (dout_imag !== THREE) begin n_fail++; $display("FAIL %s dout_imag got %h want %h", tag, dout_imag, THREE); end
            end
        end
    endtask

    task automatic test_backpressure();
        lat = 1;
        @(negedge clk);
        din_real = RAMP; din_imag = '0; din_valid = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            din_valid = 0;
        end
        dout_busy = 1; din_valid = 1; din_real = B_RE; din_imag = RAMP;
        for (int k = 7; k <= 11; k++) begin
            @(negedge clk);
            n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp dout_valid c%0d got %0d want 1", k, dout_valid); end
            n_tests++; if (dout_real !== OUT_RAMP) begin n_fail++; $display("FAIL bp dout_real c%0d got %h want %h", k, dout_real, OUT_RAMP); end
            n_tests++; if (dout_imag !== THREE) begin n_fail++; $display("FAIL bp dout_imag c%0d got %h want %h", k, dout_imag, THREE); end
            n_tests++; if (din_busy !== 1'b1) begin n_fail++; $display("FAIL bp din_busy c%0d got %0d want 1", k, din_busy); end
            if (k == 11) dout_busy = 0;
        end
        @(negedge clk);
        n_tests++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL bp idle din_busy got %0d want 0", din_busy); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp idle dout_valid got %0d want 0", dout_valid); end
        @(negedge clk);
        din_valid = 0;
        n_tests++; if (bf_din_valid !== 1'b1) begin n_fail++; $display("FAIL bp next issue got %0d want 1", bf_din_valid); end
        n_tests++; if (bf_din_real !== B_REV_RE) begin n_fail++; $display("FAIL bp next real got %h want %h", bf_din_real, B_REV_RE); end
        n_tests++; if (bf_din_imag !== REV_RAMP) begin n_fail++; $display("FAIL bp next imag got %h want %h", bf_din_imag, REV_RAMP); end
        for (int k = 0; k < 20 && dout_valid !== 1'b1; k++) @(negedge clk);
        n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp frame B dout_valid got %0d want 1", dout_valid); end
        n_tests++; if (dout_real !== B_OUT_RE) begin n_fail++; $display("FAIL bp frame B real got %h want %h", dout_real, B_OUT_RE); end
        n_tests++; if (dout_imag !== OUT_RAMP) begin n_fail++; $display("FAIL bp frame B imag got %h want %h", dout_imag, OUT_RAMP); end
        @(negedge clk);
    endtask

    task automatic test_slow_spurious();
        int pulses;
        lat = 4;
        @(negedge clk);
        spur_v = 1;
        @(negedge clk);
        spur_v = 0;
        n_tests++; if (dout_real !== B_OUT_RE) begin n_fail++; $display("FAIL spur idle buf got %h want %h", dout_real, B_OUT_RE); end
        n_tests++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL spur idle din_busy got %0d want 0", din_busy); end
        din_real = RAMP; din_imag = '0; din_valid = 1;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            din_valid = 0; spur_v = 0;
            pulses += int'(bf_din_valid);
            n_tests++; if (bf_din_valid !== 1'(k == 1 || k == 6 || k == 11)) begin n_fail++; $display("FAIL slow bf_din_valid c%0d got %0d", k, bf_din_valid); end
            n_tests++; if (dout_valid !== 1'(k == 16)) begin n_fail++; $display("FAIL slow dout_valid c%0d got %0d", k, dout_valid); end
            if (k == 11) begin
                n_tests++; if (bf_din_real !== STAGE2) begin n_fail++; $display("FAIL slow stage2 buf got %h want %h", bf_din_real, STAGE2); end
            end
            if (k == 16) begin
                n_tests++; if (dout_real !== OUT_RAMP) begin n_fail++; $display("FAIL slow dout_real got %h want %h", dout_real, OUT_RAMP); end
                n_tests++; if (dout_imag !== THREE) begin n_fail++; $display("FAIL slow dout_imag got %h want %h", dout_imag, THREE); end
            end
            spur_v = 1'(k == 6 || k == 16);
        end
        @(negedge clk);
        spur_v = 0;
        n_tests++; if (pulses != 3) begin n_fail++; $display("FAIL slow pulse count got %0d want 3", pulses); end
        n_tests++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL slow idle din_busy got %0d want 0", din_busy); end
        n_tests++; if (dout_real !== OUT_RAMP) begin n_fail++; $display("FAIL slow out spur buf got %h want %h", dout_real, OUT_RAMP); end
    endtask

    task automatic test_reset_mid();
        lat = 4;
        @(negedge clk);
        din_real = RAMP; din_imag = '0; din_valid = 1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            din_valid = 0;
        end
        n_tests++; if (bf_step !== 2'd1) begin n_fail++; $display("FAIL rmid stage got %0d want 1", bf_step); end
        rst = 1;
        @(negedge clk);
        rst = 0; spur_v = 1;
        n_tests++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL rmid din_busy got %0d want 0", din_busy); end
        n_tests++; if (bf_din_valid !== 1'b0) begin n_fail++; $display("FAIL rmid bf_din_valid got %0d want 0", bf_din_valid); end
        n_tests++; if (bf_step !== 2'd0) begin n_fail++; $display("FAIL rmid bf_step got %0d want 0", bf_step); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rmid dout_valid got %0d want 0", dout_valid); end
        n_tests++; if (dout_real !== '0) begin n_fail++; $display("FAIL rmid dout_real got %h want 0", dout_real); end
        for (int k = 9; k <= 12; k++) begin
            @(negedge clk);
            spur_v = 0;
            n_tests++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL rmid late din_busy c%0d got %0d want 0", k, din_busy); end
            n_tests++; if (bf_din_real !== '0) begin n_fail++; $display("FAIL rmid late buf c%0d got %h want 0", k, bf_din_real); end
        end
    endtask

    task automatic test_back_to_back();
        lat = 1;
        @(negedge clk);
        din_real = RAMP; din_imag = '0; din_valid = 1; dout_busy = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) din_valid = 0;
            n_tests++; if (din_busy !== 1'(k != 8 && k != 16)) begin n_fail++; $display("FAIL b2b din_busy c%0d got %0d", k, din_busy); end
            n_tests++; if (bf_din_valid !== 1'(k == 1 || k == 3 || k == 5 || k == 9 || k == 11 || k == 13)) begin n_fail++; $display("FAIL b2b bf_din_valid c%0d got %0d", k, bf_din_valid); end
            n_tests++; if (dout_valid !== 1'(k == 7 || k == 15)) begin n_fail++; $display("FAIL b2b dout_valid c%0d got %0d", k, dout_valid); end
            if (k == 7 || k == 15) begin
                n_tests++; if (dout_real !== OUT_RAMP) begin n_fail++; $display("FAIL b2b dout_real c%0d got %h want %h", k, dout_real, OUT_RAMP); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame("single");
        test_backpressure();
        test_slow_spurious();
        test_reset_mid();
        test_single_frame("post_reset");
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1);
    end
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Iterative controller that runs a full N-point radix-2 DIT FFT through one shared single-stage butterfly datapath. It accepts a frame of 2^NPOINT complex samples and stores it bit-reversed in a frame buffer. It then issues the frame to the butterfly once per stage, with the stage index on `bf_step` (0 .. NPOINT-1), and writes each stage result back into the buffer. After the last stage it presents the finished frame downstream. It sits between the sample source and the FFT output consumer, and owns the butterfly's `bf_*` handshake.

## Interface
- WIDTH, 16, bits per real/imag lane
- NPOINT, 3, log2 of FFT size; frame = 2^NPOINT lanes; NPOINT >= 1
- STEP_W, max(1,$clog2(NPOINT)), width of `bf_step` (derived localparam)
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous reset, active-high
- din_valid  in  1  input frame valid
- din_busy  out  1  1 = frame not accepted this cycle
- din_real, din_imag  in  WIDTH*2^NPOINT  input lanes; lane i at [i*WIDTH +: WIDTH]
- bf_din_valid  out  1  one-cycle start pulse to butterfly
- bf_step  out  STEP_W  stage index for butterfly (span 2^bf_step)
- bf_din_real, bf_din_imag  out  WIDTH*2^NPOINT  frame buffer contents
- bf_dout_valid  in  1  butterfly result valid
- bf_dout_real, bf_dout_imag  in  WIDTH*2^NPOINT  butterfly result
- dout_valid  out  1  output frame valid
- dout_busy  in  1  downstream not ready
- dout_real, dout_imag  out  WIDTH*2^NPOINT  output frame

## Operation
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Transfer rules:
  - Input transfer occurs when `din_valid && !din_busy`.
  - Output transfer occurs when `dout_valid && !dout_busy`.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - `din_busy`=0.
  - On input transfer, write `buf[bitrev(i)] <= din[i]` for all lanes, clear the stage counter `s`, and go to ISSUE.
- ISSUE:
  - `bf_din_valid`=1 for exactly this cycle; `bf_step`=s.
  - Go to WAIT.
- WAIT:
  - `bf_din_valid`=0.
  - On `bf_dout_valid`, write `buf <= bf_dout`.
  - If s==NPOINT-1, go to OUT; otherwise s <= s+1 and go to ISSUE.
  - With no `bf_dout_valid`, remain in WAIT indefinitely. There is no timeout.
- OUT:
  - `dout_valid`=1; `dout` = buf, held stable.
  - On output transfer, go to IDLE.
- `din_busy`=1 in every state except IDLE. `din_valid` is ignored while busy.
- `bf_din_*` and `dout_*` are driven from buf at all times. Only their strobes are gated.
- `bf_dout_valid` is ignored outside WAIT, including a same-cycle pulse during ISSUE.
- No arithmetic is performed. bitrev() reverses the NPOINT-bit lane index. NPOINT=1 makes bitrev the identity.
- `rst` in any state:
  - Next state IDLE, s=0, buf=0.
  - Any frame in flight is discarded.
  - A late `bf_dout_valid` after reset is ignored.

## Timing
- Reset values:
  - `din_busy`=0, `bf_din_valid`=0, `bf_step`=0, `dout_valid`=0.
  - `bf_din_real`/`bf_din_imag`/`dout_real`/`dout_imag`=0.
- Input accept cycle c0. Let L = cycles from `bf_din_valid` to `bf_dout_valid` (L >= 1).
  - Stage k issues at c0+1+k(L+1).
  - The last result is captured at c0+NPOINT(L+1).
  - `dout_valid` rises at c0+NPOINT(L+1)+1.
- Output transfer at cycle t puts the block in IDLE at t+1. The earliest next accept is t+1.
- Minimum frame period is NPOINT(L+1)+2 cycles (8 for NPOINT=3, L=1).
- All outputs are registered or decoded from registered state. There are no combinational paths from `din_valid`, `bf_dout_valid` or `dout_busy` to any output.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs.
  - Required: all outputs 0 and `din_busy`=0 in the cycle after `rst` is released.
- Single frame, NPOINT=3, L=1. Stimulus: real lanes 0..7 = 0..7, imag = 0. Butterfly model adds 1 to every lane.
  - First `bf_din_real` = 0,4,2,6,1,5,3,7.
  - `bf_step` = 0,1,2 at c0+1, c0+3, c0+5.
  - `dout_valid` at c0+7 with real = 3,7,5,9,4,8,6,10.
- Backpressure: `dout_busy`=1 for 5 cycles in OUT, with `din_valid`=1 throughout.
  - `dout` stays stable and `din_busy`=1 throughout.
  - After `dout_busy` drops, IDLE follows and the new frame is accepted the next cycle.
- Slow and spurious butterfly: L=4, plus extra `bf_dout_valid` pulses in IDLE, ISSUE and OUT.
  - Exactly 3 single-cycle `bf_din_valid` pulses per frame.
  - Spurious pulses do not alter buf.
  - `dout_valid` at c0+16.
- Reset mid-frame: assert `rst` during stage-1 WAIT, then pulse `bf_dout_valid`.
  - IDLE next cycle, outputs 0, late pulse ignored.
  - A following frame produces correct results.
- Back-to-back: `din_valid` held high with `dout_busy`=0.
  - Frames accepted at c0 and c0+8.
  - `dout_valid` pulses at c0+7 and c0+15.
